// File: rtl/mon_pkg.sv
// Shared state and cause-code types for the data-memory write monitor.
package mon_pkg;

  localparam int CAUSE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } mon_state_t;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISMATCH = 2'd1,
    CAUSE_TIMEOUT  = 2'd2,
    CAUSE_EMPTY    = 2'd3
  } mon_cause_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit for full/empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // status flags and head view
  always_comb begin
    empty     = (wptr_r == rptr_r);
    full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    count     = wptr_r - rptr_r;
    rdata     = mem_r[rptr_r[AW-1:0]];
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
  end

  // pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

  // storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/mem_write_monitor.sv
// Checks observed data-memory stores against a loaded list of expected
// (address, data) pairs and reports pass/fail with a cause and a watchdog.
module mem_write_monitor
  import mon_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096,
  parameter int STRICT  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         exp_valid,
  input  logic [ADDR_W-1:0]            exp_addr,
  input  logic [DATA_W-1:0]            exp_data,
  output logic                         exp_ready,
  input  logic                         MemWrite,
  input  logic [ADDR_W-1:0]            DataAdr,
  input  logic [DATA_W-1:0]            WriteData,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [CAUSE_W-1:0]           cause,
  output logic [ADDR_W-1:0]            fail_addr,
  output logic [$clog2(DEPTH+1)-1:0]   match_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = $clog2(DEPTH+1);
  localparam int CW = $clog2(TIMEOUT);
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0] MC_ONE   = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LAST_ONE = {{AW{1'b0}}, 1'b1};
  localparam bit            STRICT_B = (STRICT != 0);

  mon_state_t          state_r;
  mon_cause_t          cause_r;
  logic                done_r;
  logic                pass_r;
  logic                fail_r;
  logic [ADDR_W-1:0]   fail_addr_r;
  logic [MW-1:0]       match_count_r;
  logic [CW-1:0]       cnt_r;

  logic [EW-1:0]       head_s;
  logic                full_s;
  logic                empty_s;
  logic [AW:0]         count_s;
  logic                push_s;
  logic                pop_s;
  logic                wr_s;
  logic                hit_s;
  logic                last_s;
  logic                timeout_s;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata ({exp_addr, exp_data}),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // load handshake and store comparator; === keeps X/Z on the bus a non-match
  always_comb begin
    exp_ready = (state_r == ST_IDLE) && !full_s && !start;
    push_s    = exp_valid && exp_ready;
    wr_s      = (MemWrite === 1'b1);
    hit_s     = wr_s && !empty_s
                && (DataAdr === head_s[EW-1:DATA_W])
                && (WriteData === head_s[DATA_W-1:0]);
    pop_s     = (state_r == ST_RUN) && hit_s;
    last_s    = hit_s && (count_s == LAST_ONE);
    timeout_s = (cnt_r == CNT_LAST);
  end

  // check sequencer with registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cause_r       <= CAUSE_NONE;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      fail_r        <= 1'b0;
      fail_addr_r   <= '0;
      match_count_r <= '0;
      cnt_r         <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            cnt_r         <= '0;
            match_count_r <= '0;
            if (empty_s) begin
              state_r <= ST_FAIL;
              done_r  <= 1'b1;
              fail_r  <= 1'b1;
              cause_r <= CAUSE_EMPTY;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (cnt_r != CNT_LAST) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
          if (hit_s) begin
            match_count_r <= match_count_r + MC_ONE;
          end
          // a final match wins over a same-cycle timeout
          if (last_s) begin
            state_r <= ST_PASS;
            done_r  <= 1'b1;
            pass_r  <= 1'b1;
          end else if (STRICT_B && wr_s && !hit_s) begin
            state_r     <= ST_FAIL;
            done_r      <= 1'b1;
            fail_r      <= 1'b1;
            cause_r     <= CAUSE_MISMATCH;
            fail_addr_r <= DataAdr;
          end else if (timeout_s) begin
            state_r <= ST_FAIL;
            done_r  <= 1'b1;
            fail_r  <= 1'b1;
            cause_r <= CAUSE_TIMEOUT;
          end
        end
        ST_PASS: begin
          state_r <= ST_PASS;
        end
        ST_FAIL: begin
          state_r <= ST_FAIL;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign done        = done_r;
  assign pass        = pass_r;
  assign fail        = fail_r;
  assign cause       = cause_r;
  assign fail_addr   = fail_addr_r;
  assign match_count = match_count_r;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Randomized self-checking bench: a lenient and a strict monitor share one bus
// and are compared every cycle against a queue-based reference model.
module tb_mem_write_monitor;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int MW      = $clog2(DEPTH+1);

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PASS = 2;
  localparam int M_FAIL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              start;
  logic              exp_valid;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              MemWrite;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;

  logic              rdy_o   [2];
  logic              done_o  [2];
  logic              pass_o  [2];
  logic              fail_o  [2];
  logic [1:0]        cause_o [2];
  logic [ADDR_W-1:0] faddr_o [2];
  logic [MW-1:0]     mc_o    [2];

  mem_write_monitor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                      .TIMEOUT(TIMEOUT), .STRICT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .exp_valid(exp_valid),
    .exp_addr(exp_addr), .exp_data(exp_data), .exp_ready(rdy_o[0]),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .done(done_o[0]), .pass(pass_o[0]), .fail(fail_o[0]), .cause(cause_o[0]),
    .fail_addr(faddr_o[0]), .match_count(mc_o[0])
  );

  mem_write_monitor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                      .TIMEOUT(TIMEOUT), .STRICT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .exp_valid(exp_valid),
    .exp_addr(exp_addr), .exp_data(exp_data), .exp_ready(rdy_o[1]),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .done(done_o[1]), .pass(pass_o[1]), .fail(fail_o[1]), .cause(cause_o[1]),
    .fail_addr(faddr_o[1]), .match_count(mc_o[1])
  );

  int tests_run  = 0;
  int tests_fail = 0;

  // reference model: status, matches, RUN cycles elapsed, cause, fail address
  int                m_st   [2];
  int                m_mc   [2];
  int                m_runc [2];
  int                m_cz   [2];
  logic [ADDR_W-1:0] m_fa   [2];
  logic [63:0]       m_q    [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_edge();
    bit          idle0;
    bit          any_run;
    bit          hit;
    logic [63:0] w;
    if (reset) begin
      m_q.delete();
      for (int i = 0; i < 2; i++) begin
        m_st[i] = M_IDLE; m_mc[i] = 0; m_runc[i] = 0; m_cz[i] = 0; m_fa[i] = '0;
      end
      return;
    end
    w       = {DataAdr, WriteData};
    idle0   = (m_st[0] == M_IDLE);
    any_run = (m_st[0] == M_RUN) || (m_st[1] == M_RUN);
    hit     = any_run && (MemWrite == 1'b1) && (m_q.size() > 0) && (w == m_q[0]);
    for (int i = 0; i < 2; i++) begin
      case (m_st[i])
        M_IDLE: if (start) begin
          if (m_q.size() == 0) begin
            m_st[i] = M_FAIL; m_cz[i] = 3;
          end else begin
            m_st[i] = M_RUN; m_mc[i] = 0; m_runc[i] = 0;
          end
        end
        M_RUN: begin
          m_runc[i]++;
          if (hit) m_mc[i]++;
          if (hit && m_q.size() == 1) m_st[i] = M_PASS;
          else if (i == 1 && MemWrite && !hit) begin
            m_st[i] = M_FAIL; m_cz[i] = 1; m_fa[i] = DataAdr;
          end else if (m_runc[i] >= TIMEOUT) begin
            m_st[i] = M_FAIL; m_cz[i] = 2;
          end
        end
        default: ;
      endcase
    end
    if (hit) void'(m_q.pop_front());
    if (idle0 && exp_valid && !start && m_q.size() < DEPTH) m_q.push_back({exp_addr, exp_data});
  endtask

  // one clock: check exp_ready on current inputs, advance model, check registered outputs
  task automatic step();
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!reset)
        chk($sformatf("exp_ready[%0d]", i), {63'd0, rdy_o[i]},
            {63'd0, (m_st[i] == M_IDLE) && (m_q.size() < DEPTH) && !start});
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("done[%0d]", i),  {63'd0, done_o[i]}, {63'd0, m_st[i] == M_PASS || m_st[i] == M_FAIL});
      chk($sformatf("pass[%0d]", i),  {63'd0, pass_o[i]}, {63'd0, m_st[i] == M_PASS});
      chk($sformatf("fail[%0d]", i),  {63'd0, fail_o[i]}, {63'd0, m_st[i] == M_FAIL});
      chk($sformatf("cause[%0d]", i), {62'd0, cause_o[i]}, 64'(m_cz[i]));
      chk($sformatf("fail_addr[%0d]", i), {32'd0, faddr_o[i]}, {32'd0, m_fa[i]});
      chk($sformatf("match_count[%0d]", i), 64'(mc_o[i]), 64'(m_mc[i]));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    exp_valid = 1'b1; exp_addr = a; exp_data = d; step(); exp_valid = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d; step(); MemWrite = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  int k_fail;

  initial begin
    reset = 1'b1; start = 1'b0; exp_valid = 1'b0; exp_addr = 32'd0; exp_data = 32'd0;
    MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_mc[i] = 0; m_runc[i] = 0; m_cz[i] = 0; m_fa[i] = '0;
    end
    @(negedge clk);
    do_reset();
    step();

    // ignored wrong write then correct one
    load(32'd100, 32'd7);
    do_start();
    bus_write(32'd96, 32'd3);
    bus_write(32'd100, 32'd7);
    step();
    chk("lenient_pass", {63'd0, pass_o[0]}, 64'd1);
    chk("lenient_count", 64'(mc_o[0]), 64'd1);
    chk("strict_cause", {62'd0, cause_o[1]}, 64'd1);
    chk("strict_fail_addr", {32'd0, faddr_o[1]}, 64'd96);

    // watchdog: fail must appear exactly TIMEOUT edges after RUN entry
    do_reset();
    load(32'h20, 32'd1);
    load(32'h24, 32'd2);
    do_start();
    bus_write(32'h20, 32'd1);
    k_fail = 0;
    for (int k = 2; k < TIMEOUT + 10; k++) begin
      step();
      if (fail_o[0] && k_fail == 0) k_fail = k;
    end
    chk("timeout_edge", 64'(k_fail), 64'(TIMEOUT));
    chk("timeout_cause", {62'd0, cause_o[0]}, 64'd2);

    // fill past capacity with exp_valid held, then drain in order, twice
    for (int r = 0; r < 2; r++) begin
      do_reset();
      exp_valid = 1'b1;
      for (int e = 0; e <= DEPTH; e++) begin
        exp_addr = 32'h100 + 32'(e * 4); exp_data = 32'(r * 16 + e); step();
      end
      exp_valid = 1'b0;
      chk("full_ready", {63'd0, rdy_o[0]}, 64'd0);
      do_start();
      for (int e = 0; e < DEPTH; e++) bus_write(32'h100 + 32'(e * 4), 32'(r * 16 + e));
      chk("drain_pass", {63'd0, pass_o[1]}, 64'd1);
    end

    // start with nothing loaded
    do_reset();
    do_start();
    chk("empty_cause", {62'd0, cause_o[0]}, 64'd3);

    // reset mid-run, reload and rerun
    do_reset();
    load(32'h30, 32'd5);
    load(32'h34, 32'd6);
    do_start();
    bus_write(32'h30, 32'd5);
    reset = 1'b1; step(); reset = 1'b0;
    step();
    load(32'h30, 32'd5);
    load(32'h34, 32'd6);
    do_start();
    bus_write(32'h30, 32'd5);
    bus_write(32'h34, 32'd6);
    chk("rerun_pass", {63'd0, pass_o[0]}, 64'd1);

    // randomized sessions on a small address/data space
    for (int it = 0; it < 24; it++) begin
      do_reset();
      for (int c = 0; c < $urandom_range(0, DEPTH + 3); c++) begin
        exp_valid = ($urandom_range(0, 3) != 0);
        exp_addr  = 32'h40 + 32'($urandom_range(0, 3) * 4);
        exp_data  = 32'($urandom_range(0, 3));
        step();
      end
      start = 1'b1; exp_valid = $urandom_range(0, 1) == 1; step();
      start = 1'b0; exp_valid = 1'b0;
      for (int c = 0; c < TIMEOUT + 6; c++) begin
        if (it % 6 == 5 && c == 8) reset = 1'b1;
        else reset = 1'b0;
        MemWrite = ($urandom_range(0, 2) != 0);
        if (m_q.size() > 0 && $urandom_range(0, 1) == 1) begin
          DataAdr = m_q[0][63:32]; WriteData = m_q[0][31:0];
        end else begin
          DataAdr = 32'h40 + 32'($urandom_range(0, 3) * 4);
          WriteData = 32'($urandom_range(0, 3));
        end
        start = (c > 8) && ($urandom_range(0, 15) == 0);
        step();
      end
      reset = 1'b0; start = 1'b0; MemWrite = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
